// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter: 8088/8237A hold-acknowledge arbiter; waits for an idle bus before granting.
// Define DMA_ARB_LOCK_EN to also require lock_n high before a grant.
module dma_bus_arbiter #(
  parameter int PASSIVE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hrq,
  input  logic [2:0] s_n,
  input  logic       lock_n,
  output logic       hlda,
  output logic       aen,
  output logic       cpu_hold
);
  typedef enum logic [2:0] {IDLE, WAIT, SYNC, GRANT, RELEASE} state_t;
  state_t state_q, state_d;
  logic [2:0] pcnt_q, pcnt_d;
  logic bus_ok;
`ifdef DMA_ARB_LOCK_EN
  assign bus_ok = &s_n & lock_n;
`else
  logic unused_lock;
  assign unused_lock = lock_n;
  assign bus_ok = &s_n;
`endif
  always_comb begin
    state_d = IDLE;
    pcnt_d  = '0;
    case (state_q)
      IDLE:    state_d = hrq ? WAIT : IDLE;
      WAIT: begin
        pcnt_d  = bus_ok ? pcnt_q + 3'd1 : 3'd0;
        state_d = !hrq ? IDLE :
                  (bus_ok && (pcnt_q + 3'd1 == 3'(PASSIVE_CYCLES))) ? SYNC : WAIT;
      end
      SYNC:    state_d = hrq ? GRANT : IDLE;
      GRANT:   state_d = hrq ? GRANT : RELEASE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
    end
  end
  assign hlda     = state_q == GRANT;
  assign aen      = state_q == GRANT || state_q == RELEASE;
  assign cpu_hold = state_q == SYNC || state_q == GRANT || state_q == RELEASE;
endmodule

// File: tb/tb_dma_bus_arbiter.sv
// tb_dma_bus_arbiter: directed vectors checking {hlda,aen,cpu_hold} after each clock edge.
module tb_dma_bus_arbiter;
  logic clk = 0, reset = 1, hrq = 0, lock_n = 1;
  logic [2:0] s_n = 3'b111;
  logic hlda, aen, cpu_hold;
  int checks = 0, errors = 0;

  dma_bus_arbiter dut (
    .clk(clk), .reset(reset), .hrq(hrq), .s_n(s_n), .lock_n(lock_n),
    .hlda(hlda), .aen(aen), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: hlda/aen/cpu_hold got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic h, input logic [2:0] s, input logic l,
                     input logic [2:0] exp);
    hrq = h; s_n = s; lock_n = l;
    @(posedge clk); #1;
    check(tag, {hlda, aen, cpu_hold}, exp);
  endtask

  initial begin
    reset = 1; hrq = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset", {hlda, aen, cpu_hold}, 3'b000);
    reset = 0;
    cyc("basic_e0",  1, 3'b111, 1, 3'b000);
    cyc("basic_e1",  1, 3'b111, 1, 3'b000);
    cyc("basic_e2",  1, 3'b111, 1, 3'b001);
    cyc("basic_e3",  1, 3'b111, 1, 3'b111);
    cyc("basic_hold",1, 3'b111, 1, 3'b111);
    cyc("basic_r0",  0, 3'b111, 1, 3'b011);
    cyc("basic_r1",  0, 3'b111, 1, 3'b000);

    cyc("busy_e0",   1, 3'b111, 1, 3'b000);
    cyc("busy_w1",   1, 3'b111, 1, 3'b000);
    cyc("busy_w2",   1, 3'b100, 1, 3'b000);
    cyc("busy_w3",   1, 3'b111, 1, 3'b000);
    cyc("busy_w4",   1, 3'b111, 1, 3'b001);
    cyc("busy_grant",1, 3'b000, 1, 3'b111);
    cyc("busy_r0",   0, 3'b000, 1, 3'b011);
    cyc("rerq_idle", 1, 3'b111, 1, 3'b000);
    cyc("rerq_wait", 1, 3'b111, 1, 3'b000);
    cyc("rerq_w1",   1, 3'b111, 1, 3'b000);
    cyc("rerq_sync", 1, 3'b111, 1, 3'b001);
    cyc("rerq_grant",1, 3'b111, 1, 3'b111);
    cyc("rerq_r0",   0, 3'b111, 1, 3'b011);
    cyc("rerq_r1",   0, 3'b111, 1, 3'b000);

    cyc("abw_e0",    1, 3'b111, 1, 3'b000);
    cyc("abw_e1",    1, 3'b111, 1, 3'b000);
    cyc("abw_drop",  0, 3'b111, 1, 3'b000);
    cyc("abw_idle",  0, 3'b111, 1, 3'b000);
    cyc("abs_e0",    1, 3'b111, 1, 3'b000);
    cyc("abs_e1",    1, 3'b111, 1, 3'b000);
    cyc("abs_sync",  1, 3'b111, 1, 3'b001);
    cyc("abs_drop",  0, 3'b111, 1, 3'b000);
    cyc("abs_idle",  0, 3'b111, 1, 3'b000);

`ifdef DMA_ARB_LOCK_EN
    for (int i = 0; i < 10; i++) cyc("lock_held", 1, 3'b111, 0, 3'b000);
    cyc("lock_rel0", 1, 3'b111, 1, 3'b000);
    cyc("lock_sync", 1, 3'b111, 1, 3'b001);
    cyc("lock_grant",1, 3'b111, 1, 3'b111);
`else
    cyc("nolock_e0", 1, 3'b111, 0, 3'b000);
    cyc("nolock_e1", 1, 3'b111, 0, 3'b000);
    cyc("nolock_e2", 1, 3'b111, 0, 3'b001);
    cyc("nolock_e3", 1, 3'b111, 0, 3'b111);
`endif

    reset = 1;
    cyc("rst_grant", 1, 3'b111, 1, 3'b000);
    reset = 0;
    cyc("rst_e0",    1, 3'b111, 1, 3'b000);
    cyc("rst_e1",    1, 3'b111, 1, 3'b000);
    cyc("rst_e2",    1, 3'b111, 1, 3'b001);
    cyc("rst_e3",    1, 3'b111, 1, 3'b111);
    cyc("rst_r0",    0, 3'b111, 1, 3'b011);
    cyc("rst_r1",    0, 3'b111, 1, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
